reg_dump_unit: RTL

- Debug-side consumer sitting directly downstream of riscv_core's debug and status outputs.
- On a start request, it snapshots the core PC. It then walks the register file through the core's debug read port (rs_dbg_addr/rs_dbg_data).
- It serialises everything into a framed byte stream over a valid/ready interface that feeds the UART transmitter.
- Used to report architectural state after ECALL halt without a simulator.

---
 rtl/reg_dump_pkg.sv | 25 ++
 rtl/word_serializer.sv | 56 +++++
 rtl/reg_dump_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared types and helpers for the register dump unit.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, default frame header byte, frame length helper.
package reg_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PC,
    ST_RADDR,
    ST_RWAIT,
    ST_RBYTES,
    ST_CSUM,
    ST_DONE
  } state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Bytes in one frame: header + 4 PC bytes + 4 bytes per register (+ checksum).
  function automatic int frame_len(input int num_regs, input bit csum);
    return 5 + 4 * num_regs + (csum ? 1 : 0);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits a 32-bit word into 4 little-endian bytes on a valid/ready stream.
// Latency: first byte valid the cycle after load_i; then 1 byte per accepted cycle.
// Backpressure: byte and valid held stable while rdy_i is low.
// Ports: clk_i/rst_i (sync, active-high); load_i/word_i load a new word;
//        rdy_i downstream ready; dat_o/vld_o stream byte; last_o marks byte 3.
module word_serializer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        rdy_i,
  output logic [7:0]  dat_o,
  output logic        vld_o,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        vld_q, vld_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    if (load_i) begin
      word_d = word_i;
      cnt_d  = 2'd0;
      vld_d  = 1'b1;
    end else if (vld_q && rdy_i) begin
      if (cnt_q == 2'd3) begin
        // Keep the last byte in place so the output does not change after the word.
        vld_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + 2'd1;
        word_d = {8'h00, word_q[31:8]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  assign dat_o  = word_q[7:0];
  assign vld_o  = vld_q;
  assign last_o = (cnt_q == 2'd3);

endmodule

// File: rtl/reg_dump_unit.sv
// Snapshots the halted core PC, walks the register file over the debug read port
// and streams a framed little-endian byte dump: header, PC, x0..x(NUM_REGS-1).
// Latency: first byte valid the cycle after an accepted start; 1 byte/cycle inside a word.
// Backpressure: tx_data_o/tx_valid_o held stable while tx_ready_i is low.
// Optional: define REG_DUMP_CHECKSUM_EN to append an XOR checksum of all prior frame bytes.
// Ports: clk_i, rst_i (sync active-high); start_i, core_pc_i, core_halted_i from the core;
//        rs_dbg_addr_o/rs_dbg_data_i register file debug read; tx_* byte stream;
//        busy_o frame in progress; done_o one-cycle pulse after the last byte.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int         NUM_REGS        = 32,
  parameter int         RF_READ_LATENCY = 1,
  parameter logic [7:0] HEADER_BYTE     = HEADER_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] core_pc_i,
  input  logic        core_halted_i,
  output logic [4:0]  rs_dbg_addr_o,
  input  logic [31:0] rs_dbg_data_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  addr_q, addr_d;
  logic [1:0]  wait_q, wait_d;
  logic        own_vld_q, own_vld_d;   // header / checksum byte owned by this module
  logic [7:0]  own_dat_q, own_dat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;

  logic        ser_load;
  logic [31:0] ser_word;
  logic [7:0]  ser_dat;
  logic        ser_vld;
  logic        ser_last;
  logic        ser_acc;
  logic        own_acc;
  logic        tx_acc;
  logic        start_acc;

  word_serializer u_ser (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (ser_load),
    .word_i (ser_word),
    .rdy_i  (tx_ready_i),
    .dat_o  (ser_dat),
    .vld_o  (ser_vld),
    .last_o (ser_last)
  );

  // Own bytes and serializer bytes are never valid at the same time.
  assign tx_valid_o    = own_vld_q | ser_vld;
  assign tx_data_o     = own_vld_q ? own_dat_q : ser_dat;
  assign rs_dbg_addr_o = addr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

  assign ser_acc   = ser_vld & tx_ready_i;
  assign own_acc   = own_vld_q & tx_ready_i;
  assign tx_acc    = tx_valid_o & tx_ready_i;
  assign start_acc = (state_q == ST_IDLE) && start_i && core_halted_i;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic [7:0] csum_nxt;

  // Running XOR including the byte accepted this cycle.
  assign csum_nxt = csum_q ^ (tx_acc ? tx_data_o : 8'h00);

  always_comb begin
    csum_d = start_acc ? 8'h00 : csum_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) csum_q <= 8'h00;
    else       csum_q <= csum_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    own_vld_d  = own_vld_q;
    own_dat_d  = own_dat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ser_load   = 1'b0;
    ser_word   = pc_q;
    byte_cnt_d = start_acc ? 8'd0 : byte_cnt_q + {7'd0, tx_acc};

    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d   = ST_HDR;
          pc_d      = core_pc_i;
          idx_d     = 5'd0;
          busy_d    = 1'b1;
          own_vld_d = 1'b1;
          own_dat_d = HEADER_BYTE;
        end
      end
      ST_HDR: begin
        if (own_acc) begin
          own_vld_d = 1'b0;
          ser_load  = 1'b1;
          ser_word  = pc_q;
          state_d   = ST_PC;
        end
      end
      ST_PC: begin
        if (ser_acc && ser_last) begin
          addr_d  = idx_q;
          state_d = ST_RADDR;
        end
      end
      ST_RADDR: begin
        // Zero-latency register file: data already follows the address this cycle.
        if (RF_READ_LATENCY == 0) begin
          ser_load = 1'b1;
          ser_word = rs_dbg_data_i;
          state_d  = ST_RBYTES;
        end else begin
          wait_d  = 2'd1;
          state_d = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (wait_q == 2'(RF_READ_LATENCY)) begin
          ser_load = 1'b1;
          ser_word = rs_dbg_data_i;
          state_d  = ST_RBYTES;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_RBYTES: begin
        if (ser_acc && ser_last) begin
          // idx stops at the last register instead of wrapping.
          if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
            own_vld_d = 1'b1;
            own_dat_d = csum_nxt;
            state_d   = ST_CSUM;
`else
            done_d  = 1'b1;
            state_d = ST_DONE;
`endif
          end else begin
            idx_d   = idx_q + 5'd1;
            addr_d  = idx_q + 5'd1;
            state_d = ST_RADDR;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (own_acc) begin
          own_vld_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      wait_q     <= '0;
      own_vld_q  <= 1'b0;
      own_dat_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wait_q     <= wait_d;
      own_vld_q  <= own_vld_d;
      own_dat_q  <= own_dat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // A completed frame must have carried exactly one frame's worth of bytes.
  always_ff @(posedge clk_i) begin
    if (!rst_i && done_q) begin
      assert (int'(byte_cnt_q) == frame_len(NUM_REGS, CSUM_ON));
    end
  end

endmodule
